// File: rtl/awg_pkg.sv
// rtl/awg_pkg.sv - field encodings, amplitude limits and widths shared with the waveform generators
package awg_pkg;

  localparam int FREQ_W  = 12;
  localparam int AMP_W   = 3;
  localparam int PHASE_W = 8;

  localparam logic [AMP_W-1:0] AMP_MIN = 3'd1;
  localparam logic [AMP_W-1:0] AMP_MAX = 3'd7;

  typedef enum logic [1:0] {
    FIELD_FREQ  = 2'd0,
    FIELD_AMP   = 2'd1,
    FIELD_PHASE = 2'd2
  } field_e;

  function automatic field_e next_field(input field_e f);
    case (f)
      FIELD_FREQ: return FIELD_AMP;
      FIELD_AMP:  return FIELD_PHASE;
      default:    return FIELD_FREQ;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchronizer, debouncer, press pulse and optional auto-repeat
module key_debounce #(
  parameter int DEB_CYCLES  = 20000,
  parameter int HOLD_CYCLES = 400000,
  parameter int REP_CYCLES  = 100000,
  parameter bit REPEAT_EN   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rep_evt
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REP_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REP_CYCLES - 1);

  logic          sync1, sync2, armed, level_d;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic          raw_pressed;

  assign raw_pressed = ~sync2;

  // Sync stages reset to "low" so a key held through reset never arms; arming needs a real released sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      armed <= armed | sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      level   <= 1'b0;
    end else if (!armed || raw_pressed == level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      level   <= raw_pressed;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

  // Hold counter saturates at HOLD_CYCLES; the repeat phase counter then free-runs modulo REP_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
      rep_evt  <= 1'b0;
    end else begin
      rep_evt <= REPEAT_EN && level && (hold_cnt == HOLD_END) && (rep_cnt == '0);
      if (!level) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_END) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (!level || hold_cnt != HOLD_END) begin
        rep_cnt <= '0;
      end else if (rep_cnt == REP_LAST) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/awg_param_ctrl.sv
// rtl/awg_param_ctrl.sv - front-panel field editor driving generator enable, frequency, amplitude and phase
module awg_param_ctrl
  import awg_pkg::*;
#(
  parameter int DEB_CYCLES  = 20000,
  parameter int HOLD_CYCLES = 400000,
  parameter int REP_CYCLES  = 100000,
  parameter int FREQ_STEP   = 1,
  parameter int FREQ_MIN    = 1,
  parameter int FREQ_MAX    = 4095,
  parameter int FREQ_RST    = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_sel_n,
  input  logic               key_up_n,
  input  logic               key_dn_n,
  input  logic               key_en_n,
  output logic               en,
  output logic [FREQ_W-1:0]  state_freq,
  output logic [AMP_W-1:0]   state_amp,
  output logic [PHASE_W-1:0] state_phase,
  output logic [1:0]         field_sel
);

  localparam int XW = FREQ_W + 1;
  localparam logic [XW-1:0]     FREQ_MAX_X = XW'(FREQ_MAX);
  localparam logic [XW-1:0]     FREQ_LO_X  = XW'(FREQ_MIN + FREQ_STEP);
  localparam logic [XW-1:0]     STEP_X     = XW'(FREQ_STEP);
  localparam logic [FREQ_W-1:0] STEP_F     = FREQ_W'(FREQ_STEP);

  logic [3:0] key_raw_n, evt;
  assign key_raw_n = {key_en_n, key_dn_n, key_up_n, key_sel_n};

  // evt bits: 0 sel, 1 up, 2 dn, 3 en; only up/dn auto-repeat.
  for (genvar i = 0; i < 4; i++) begin : g_key
    logic press, rep;
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .REP_CYCLES (REP_CYCLES),
      .REPEAT_EN  (i == 1 || i == 2)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .key_n  (key_raw_n[i]),
      .level  (),
      .press  (press),
      .rep_evt(rep)
    );
    assign evt[i] = press | rep;
  end

  field_e               field_q, field_nxt;
  logic                 edit_up, edit_dn;
  logic [XW-1:0]        freq_ext, freq_inc;
  logic [FREQ_W-1:0]    freq_dec, freq_nxt;
  logic [AMP_W-1:0]     amp_nxt;
  logic [PHASE_W-1:0]   phase_nxt;

  assign edit_up = evt[1] & ~evt[2] & ~evt[0];
  assign edit_dn = evt[2] & ~evt[1] & ~evt[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) field_q <= FIELD_FREQ;
    else     field_q <= field_nxt;
  end

  always_comb begin
    field_nxt = field_q;
    freq_nxt  = state_freq;
    amp_nxt   = state_amp;
    phase_nxt = state_phase;
    freq_ext  = {1'b0, state_freq};
    freq_inc  = freq_ext + STEP_X;
    freq_dec  = state_freq - STEP_F;
    if (evt[0]) begin
      field_nxt = next_field(field_q);
    end else if (edit_up || edit_dn) begin
      case (field_q)
        FIELD_FREQ: begin
          if (edit_up) freq_nxt = (freq_inc > FREQ_MAX_X) ? FREQ_MAX_X[FREQ_W-1:0] : freq_inc[FREQ_W-1:0];
          else         freq_nxt = (freq_ext < FREQ_LO_X) ? FREQ_W'(FREQ_MIN) : freq_dec;
        end
        FIELD_AMP: begin
          if (edit_up) amp_nxt = (state_amp >= AMP_MAX) ? AMP_MAX : state_amp + 3'd1;
          else         amp_nxt = (state_amp <= AMP_MIN) ? AMP_MIN : state_amp - 3'd1;
        end
        FIELD_PHASE: begin
          phase_nxt = edit_up ? state_phase + 8'd1 : state_phase - 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en          <= 1'b0;
      state_freq  <= FREQ_W'(FREQ_RST);
      state_amp   <= AMP_MIN;
      state_phase <= '0;
    end else begin
      en          <= en ^ evt[3];
      state_freq  <= freq_nxt;
      state_amp   <= amp_nxt;
      state_phase <= phase_nxt;
    end
  end

  assign field_sel = field_q;

endmodule

// File: tb/tb_awg_param_ctrl.sv
// tb/tb_awg_param_ctrl.sv - directed bench with a sample-window model of the front-panel controller
module tb_awg_param_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 32;
  localparam int REP  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_n = 4'hf;
  logic        en;
  logic [11:0] state_freq;
  logic [2:0]  state_amp;
  logic [7:0]  state_phase;
  logic [1:0]  field_sel;

  int errors = 0;
  int checks = 0;

  awg_param_ctrl #(
    .DEB_CYCLES (DEB),
    .HOLD_CYCLES(HOLD),
    .REP_CYCLES (REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_sel_n  (key_n[0]),
    .key_up_n   (key_n[1]),
    .key_dn_n   (key_n[2]),
    .key_en_n   (key_n[3]),
    .en         (en),
    .state_freq (state_freq),
    .state_amp  (state_amp),
    .state_phase(state_phase),
    .field_sel  (field_sel)
  );

  always #5 clk = ~clk;

  // Model: a key is accepted once DEB consecutive samples disagree with its accepted level;
  // the resulting event reaches the outputs 4 edges after the deciding sample.
  int run_low[4]  = '{default: 0};
  int run_high[4] = '{default: 0};
  bit armed[4]    = '{default: 0};
  bit acc[4]      = '{default: 0};
  bit accd[4][6]  = '{default: '{default: 0}};
  int press_t[4]  = '{default: 0};
  bit ev[4]       = '{default: 0};
  int edge_n = 0;
  bit m_en = 0;
  int m_freq = 64, m_amp = 1, m_phase = 0, m_field = 0;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        run_low[k] = 0; run_high[k] = 0; armed[k] = 0; acc[k] = 0; press_t[k] = 0;
        for (int i = 0; i < 6; i++) accd[k][i] = 0;
      end
      edge_n = 0;
      m_en = 0; m_freq = 64; m_amp = 1; m_phase = 0; m_field = 0;
    end else begin
      edge_n++;
      for (int k = 0; k < 4; k++) begin
        if (key_n[k]) begin
          armed[k] = 1; run_high[k]++; run_low[k] = 0;
        end else begin
          run_low[k]++; run_high[k] = 0;
        end
        if (!acc[k] && armed[k] && run_low[k] >= DEB) acc[k] = 1;
        else if (acc[k] && run_high[k] >= DEB) acc[k] = 0;
        for (int i = 5; i > 0; i--) accd[k][i] = accd[k][i-1];
        accd[k][0] = acc[k];
        ev[k] = 0;
        if (accd[k][4] && !accd[k][5]) begin
          ev[k] = 1;
          press_t[k] = edge_n;
        end else if ((k == 1 || k == 2) && accd[k][4] && (edge_n - press_t[k]) >= HOLD
                     && ((edge_n - press_t[k] - HOLD) % REP) == 0) begin
          ev[k] = 1;
        end
      end
      if (ev[3]) m_en = !m_en;
      if (ev[0]) begin
        m_field = (m_field + 1) % 3;
      end else if (ev[1] != ev[2]) begin
        case (m_field)
          0: m_freq  = clampi(m_freq + (ev[1] ? 1 : -1), 1, 4095);
          1: m_amp   = clampi(m_amp + (ev[1] ? 1 : -1), 1, 7);
          default: m_phase = (m_phase + (ev[1] ? 1 : 255)) % 256;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({en, state_freq, state_amp, state_phase, field_sel} !==
        {m_en, 12'(m_freq), 3'(m_amp), 8'(m_phase), 2'(m_field)}) begin
      errors++;
      $display("FAIL model_cmp t=%0t got en=%0b freq=%0d amp=%0d phase=%0d field=%0d expected en=%0b freq=%0d amp=%0d phase=%0d field=%0d",
               $time, en, state_freq, state_amp, state_phase, field_sel, m_en, m_freq, m_amp, m_phase, m_field);
    end
  end

  task automatic expect_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] mask, input int n);
    #2 key_n = ~mask;
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask, input int n);
    drive(mask, n);
    drive(4'b0000, 12);
  endtask

  task automatic expect_reset_state(input string tag);
    expect_eq({tag, "_en"}, int'(en), 0);
    expect_eq({tag, "_freq"}, int'(state_freq), 64);
    expect_eq({tag, "_amp"}, int'(state_amp), 1);
    expect_eq({tag, "_phase"}, int'(state_phase), 0);
    expect_eq({tag, "_field"}, int'(field_sel), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    expect_reset_state("por");
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);

    // short glitches never reach DEB samples, then one clean press lands on edge 8
    for (int g = 0; g < 3; g++) begin
      drive(4'b0010, 3);
      drive(4'b0000, 3);
    end
    #2 key_n = ~4'b0010;
    repeat (7) @(negedge clk);
    expect_eq("glitch_edge7_freq", int'(state_freq), 64);
    @(negedge clk);
    expect_eq("glitch_edge8_freq", int'(state_freq), 65);
    repeat (12) @(negedge clk);
    drive(4'b0000, 12);
    expect_eq("glitch_final_freq", int'(state_freq), 65);

    press(4'b1000, 8);
    expect_eq("en_first", int'(en), 1);
    press(4'b1000, 8);
    expect_eq("en_second", int'(en), 0);

    press(4'b0001, 8);
    press(4'b0001, 8);
    expect_eq("field_phase", int'(field_sel), 2);
    #2 key_n = ~4'b0100;
    repeat (8) @(negedge clk);
    expect_eq("dn_first_event", int'(state_phase), 255);
    repeat (31) @(negedge clk);
    expect_eq("dn_before_repeat", int'(state_phase), 255);
    @(negedge clk);
    expect_eq("dn_first_repeat", int'(state_phase), 254);
    repeat (160) @(negedge clk);
    drive(4'b0000, 15);
    expect_eq("dn_hold_final", int'(state_phase), 234);

    press(4'b0001, 8);
    press(4'b0001, 8);
    expect_eq("field_amp", int'(field_sel), 1);
    for (int i = 0; i < 10; i++) press(4'b0010, 8);
    expect_eq("amp_sat_max", int'(state_amp), 7);
    for (int i = 0; i < 10; i++) press(4'b0100, 8);
    expect_eq("amp_sat_min", int'(state_amp), 1);

    press(4'b0001, 8);
    press(4'b0001, 8);
    expect_eq("field_freq", int'(field_sel), 0);
    drive(4'b0010, 32400);
    drive(4'b0000, 15);
    expect_eq("freq_sat_max", int'(state_freq), 4095);
    drive(4'b0100, 33000);
    drive(4'b0000, 15);
    expect_eq("freq_sat_min", int'(state_freq), 1);

    press(4'b0011, 8);
    expect_eq("sel_up_field", int'(field_sel), 1);
    expect_eq("sel_up_freq", int'(state_freq), 1);
    expect_eq("sel_up_amp", int'(state_amp), 1);
    press(4'b0001, 8);
    press(4'b0110, 8);
    expect_eq("up_dn_phase", int'(state_phase), 234);

    press(4'b1000, 8);
    expect_eq("en_before_reset", int'(en), 1);

    // reset while up is held: outputs clear at once, no event until a fresh press
    #2 key_n = ~4'b0010;
    repeat (15) @(negedge clk);
    #3 rst = 1'b1;
    #1 expect_reset_state("async_rst");
    @(negedge clk);
    #3 rst = 1'b0;
    repeat (40) @(negedge clk);
    expect_eq("held_through_reset", int'(state_freq), 64);
    drive(4'b0000, 15);
    press(4'b0010, 8);
    expect_eq("repress_after_reset", int'(state_freq), 65);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
